mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 ex_valid  in  1  execute-stage result presented this cycle.
REQ-004 ex_res  in  32  ALU result: memory byte address for load/store, writeback value otherwise.
REQ-005 ex_store_data  in  32  rs2 value for stores.
REQ-006 ex_rd  in  5  destination register.
REQ-007 ex_regwrite  in  1  op writes rd.
REQ-008 ex_load / ex_store  in  1 each  op is load / store; never both high.
REQ-009 ex_funct3  in  3  access size/sign: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
REQ-010 mem_stall  out  1  upstream holds all ex_* inputs while high.
REQ-011 dmem_req  out  1  data-memory request.
REQ-012 dmem_we  out  1  request is a write.
REQ-013 dmem_addr  out  32  word address ({ex_res[31:2],2'b00}).
REQ-014 dmem_wdata  out  32  lane-replicated write data.
REQ-015 dmem_be  out  4  byte enables.
REQ-016 dmem_rdata  in  32  read data, valid with dmem_ack.
REQ-017 dmem_ack  in  1  completes the outstanding request.
REQ-018 wb_valid  out  1  writeback record valid (one-cycle pulse per accepted op).
REQ-019 wb_rd / wb_regwrite / wb_data  out  5/1/32  writeback record.
REQ-020 misalign  out  1  one-cycle pulse: misaligned access dropped.

Function
REQ-021 FSM states IDLE and ACCESS; mem_stall SHALL equal (state==ACCESS).
REQ-022 IDLE, ex_valid, no load/store: next cycle wb_valid=1, wb_data=ex_res, wb_rd/wb_regwrite copied; 1-cycle latency, no stall.
REQ-023 IDLE, ex_valid, aligned load/store: latch address, size, sign, rd, regwrite, store data; go to ACCESS.
REQ-024 Alignment: word needs addr[1:0]==00, half needs addr[0]==0, byte always aligned.
REQ-025 Misaligned load/store: stay IDLE, no dmem_req; next cycle misalign=1, wb_valid=1, wb_regwrite=0.
REQ-026 ACCESS: dmem_req=1; dmem_we/addr/wdata/be SHALL be registered and stable until ack.
REQ-027 Store byte: be=4'b0001<<addr[1:0], wdata={4{data[7:0]}}; half: be=4'b0011<<addr[1:0], wdata={2{data[15:0]}}; word: be=4'b1111, wdata=data.
REQ-028 Load: dmem_we=0, be=4'b1111; the selected byte/half is rdata shifted right by 8*addr[1:0], then sign- or zero-extended per funct3.
REQ-029 ACCESS with dmem_ack: return to IDLE; next cycle wb_valid=1, wb_data=extracted load (0 for store), wb_regwrite=latched regwrite AND load.
REQ-030 ACCESS without ack: remain indefinitely; mem_stall and dmem_req stay high; no timeout.
REQ-031 dmem_ack in IDLE SHALL be ignored.
REQ-032 funct3 011/110/111 on a load or store SHALL be treated as word size.
REQ-033 ex_valid=0 in IDLE: wb_valid=0 next cycle; wb_data/wb_rd hold previous values.
REQ-034 Ops back-to-back: IDLE may accept a new op in the cycle after ack (one bubble-free op per cycle for non-memory ops).

Reset
REQ-035 reset=1 SHALL force IDLE and, next cycle, wb_valid=0, wb_regwrite=0, wb_rd=0, wb_data=0, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, misalign=0, mem_stall=0.
REQ-036 Reset during ACCESS SHALL abandon the request with no writeback; a later dmem_ack is ignored.

Verification
REQ-037 ALU op ex_res=0x0000_1234, rd=5, regwrite=1 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x0000_1234, mem_stall never high.
REQ-038 lb at 0x0000_0103, ack after 3 cycles with rdata=0x80AA_BBCC -> dmem_addr=0x0000_0100, stall 4 cycles, wb_data=0xFFFF_FF80; same with lbu -> 0x0000_0080.
REQ-039 sh data 0x1234_ABCD at 0x0000_0202 -> dmem_we=1, be=4'b1100, wdata=0xABCD_ABCD; after ack wb_valid=1, wb_regwrite=0.
REQ-040 lw at 0x0000_0006 -> no dmem_req, misalign pulse, wb_valid=1 with wb_regwrite=0 next cycle.
REQ-041 reset asserted 2 cycles into ACCESS, ack arrives 1 cycle later -> dmem_req=0, mem_stall=0, no wb_valid.
REQ-042 Spurious dmem_ack in IDLE alongside ALU op -> only the ALU writeback occurs, data unchanged.

Source files
------------

// File: rtl/mem_stage.sv
// Memory pipeline stage: passes ALU results to writeback and runs one
// outstanding load/store at a time against a handshaked data memory.
module mem_stage (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ex_valid,
    input  logic [31:0] i_ex_res,
    input  logic [31:0] i_ex_store_data,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_regwrite,
    input  logic        i_ex_load,
    input  logic        i_ex_store,
    input  logic [2:0]  i_ex_funct3,
    output logic        o_mem_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_be,
    input  logic [31:0] i_dmem_rdata,
    input  logic        i_dmem_ack,
    output logic        o_wb_valid,
    output logic [4:0]  o_wb_rd,
    output logic        o_wb_regwrite,
    output logic [31:0] o_wb_data,
    output logic        o_misalign
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;
    localparam logic [0:0]  S_IDLE   = 1'b0;
    localparam logic [0:0]  S_ACCESS = 1'b1;

    logic [0:0]      r_state, w_state_nxt;
    logic            r_dmem_req, w_dmem_req_nxt;
    logic            r_dmem_we, w_dmem_we_nxt;
    logic [XLEN-1:0] r_dmem_addr, w_dmem_addr_nxt;
    logic [XLEN-1:0] r_dmem_wdata, w_dmem_wdata_nxt;
    logic [3:0]      r_dmem_be, w_dmem_be_nxt;
    logic            r_wb_valid, w_wb_valid_nxt;
    logic [REGW-1:0] r_wb_rd, w_wb_rd_nxt;
    logic            r_wb_regwrite, w_wb_regwrite_nxt;
    logic [XLEN-1:0] r_wb_data, w_wb_data_nxt;
    logic            r_misalign, w_misalign_nxt;
    logic [1:0]      r_off, w_off_nxt;
    logic [1:0]      r_size, w_size_nxt;
    logic            r_unsigned, w_unsigned_nxt;
    logic [REGW-1:0] r_rd, w_rd_nxt;
    logic            r_regwrite, w_regwrite_nxt;
    logic            r_load, w_load_nxt;

    logic [1:0]      w_size;
    logic            w_misal;
    logic [3:0]      w_st_be;
    logic [XLEN-1:0] w_st_wdata;
    logic [XLEN-1:0] w_ld_shift;
    logic [XLEN-1:0] w_ld_data;

    // Size code: 00 byte, 01 half, 10 word; reserved encodings fold to word.
    always_comb begin
        w_size = (i_ex_funct3[1:0] == 2'b11) ? 2'b10 : i_ex_funct3[1:0];
        case (w_size)
            2'b00:   begin w_misal = 1'b0;            w_st_be = 4'b0001 << i_ex_res[1:0]; w_st_wdata = {4{i_ex_store_data[7:0]}};  end
            2'b01:   begin w_misal = i_ex_res[0];     w_st_be = 4'b0011 << i_ex_res[1:0]; w_st_wdata = {2{i_ex_store_data[15:0]}}; end
            default: begin w_misal = |i_ex_res[1:0];  w_st_be = 4'b1111;                   w_st_wdata = i_ex_store_data;           end
        endcase
    end

    // Load lane extraction from the latched offset, size and signedness.
    always_comb begin
        w_ld_shift = i_dmem_rdata >> {r_off, 3'b000};
        case (r_size)
            2'b00:   w_ld_data = r_unsigned ? {24'b0, w_ld_shift[7:0]}  : {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
            2'b01:   w_ld_data = r_unsigned ? {16'b0, w_ld_shift[15:0]} : {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
            default: w_ld_data = w_ld_shift;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_dmem_req_nxt    = r_dmem_req;
        w_dmem_we_nxt     = r_dmem_we;
        w_dmem_addr_nxt   = r_dmem_addr;
        w_dmem_wdata_nxt  = r_dmem_wdata;
        w_dmem_be_nxt     = r_dmem_be;
        w_wb_valid_nxt    = 1'b0;
        w_wb_rd_nxt       = r_wb_rd;
        w_wb_regwrite_nxt = r_wb_regwrite;
        w_wb_data_nxt     = r_wb_data;
        w_misalign_nxt    = 1'b0;
        w_off_nxt         = r_off;
        w_size_nxt        = r_size;
        w_unsigned_nxt    = r_unsigned;
        w_rd_nxt          = r_rd;
        w_regwrite_nxt    = r_regwrite;
        w_load_nxt        = r_load;
        case (r_state)
            S_IDLE: begin
                if (i_ex_valid) begin
                    if (!(i_ex_load || i_ex_store)) begin
                        w_wb_valid_nxt    = 1'b1;
                        w_wb_data_nxt     = i_ex_res;
                        w_wb_rd_nxt       = i_ex_rd;
                        w_wb_regwrite_nxt = i_ex_regwrite;
                    end else if (w_misal) begin
                        w_wb_valid_nxt    = 1'b1;
                        w_wb_regwrite_nxt = 1'b0;
                        w_misalign_nxt    = 1'b1;
                    end else begin
                        w_state_nxt      = S_ACCESS;
                        w_dmem_req_nxt   = 1'b1;
                        w_dmem_we_nxt    = i_ex_store;
                        w_dmem_addr_nxt  = {i_ex_res[31:2], 2'b00};
                        w_dmem_wdata_nxt = w_st_wdata;
                        w_dmem_be_nxt    = i_ex_store ? w_st_be : 4'b1111;
                        w_off_nxt        = i_ex_res[1:0];
                        w_size_nxt       = w_size;
                        w_unsigned_nxt   = i_ex_funct3[2];
                        w_rd_nxt         = i_ex_rd;
                        w_regwrite_nxt   = i_ex_regwrite;
                        w_load_nxt       = i_ex_load;
                    end
                end
            end
            default: begin
                if (i_dmem_ack) begin
                    w_state_nxt       = S_IDLE;
                    w_dmem_req_nxt    = 1'b0;
                    w_wb_valid_nxt    = 1'b1;
                    w_wb_rd_nxt       = r_rd;
                    w_wb_regwrite_nxt = r_regwrite & r_load;
                    w_wb_data_nxt     = r_load ? w_ld_data : '0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dmem_req    <= 1'b0;
            r_dmem_we     <= 1'b0;
            r_dmem_addr   <= '0;
            r_dmem_wdata  <= '0;
            r_dmem_be     <= '0;
            r_wb_valid    <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_regwrite <= 1'b0;
            r_wb_data     <= '0;
            r_misalign    <= 1'b0;
            r_off         <= '0;
            r_size        <= '0;
            r_unsigned    <= 1'b0;
            r_rd          <= '0;
            r_regwrite    <= 1'b0;
            r_load        <= 1'b0;
        end else begin
            r_dmem_req    <= w_dmem_req_nxt;
            r_dmem_we     <= w_dmem_we_nxt;
            r_dmem_addr   <= w_dmem_addr_nxt;
            r_dmem_wdata  <= w_dmem_wdata_nxt;
            r_dmem_be     <= w_dmem_be_nxt;
            r_wb_valid    <= w_wb_valid_nxt;
            r_wb_rd       <= w_wb_rd_nxt;
            r_wb_regwrite <= w_wb_regwrite_nxt;
            r_wb_data     <= w_wb_data_nxt;
            r_misalign    <= w_misalign_nxt;
            r_off         <= w_off_nxt;
            r_size        <= w_size_nxt;
            r_unsigned    <= w_unsigned_nxt;
            r_rd          <= w_rd_nxt;
            r_regwrite    <= w_regwrite_nxt;
            r_load        <= w_load_nxt;
        end
    end

    assign o_mem_stall   = (r_state == S_ACCESS);
    assign o_dmem_req    = r_dmem_req;
    assign o_dmem_we     = r_dmem_we;
    assign o_dmem_addr   = r_dmem_addr;
    assign o_dmem_wdata  = r_dmem_wdata;
    assign o_dmem_be     = r_dmem_be;
    assign o_wb_valid    = r_wb_valid;
    assign o_wb_rd       = r_wb_rd;
    assign o_wb_regwrite = r_wb_regwrite;
    assign o_wb_data     = r_wb_data;
    assign o_misalign    = r_misalign;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: single-cycle vector table, directed memory sequences,
// and randomized ops checked against an arithmetic reference model.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [31:0] ex_res;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_load;
    logic        ex_store;
    logic [2:0]  ex_funct3;
    logic        mem_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic [31:0] wb_data;
    logic        misalign;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage dut (
        .i_clk(clk), .i_reset(reset), .i_ex_valid(ex_valid), .i_ex_res(ex_res),
        .i_ex_store_data(ex_store_data), .i_ex_rd(ex_rd), .i_ex_regwrite(ex_regwrite),
        .i_ex_load(ex_load), .i_ex_store(ex_store), .i_ex_funct3(ex_funct3),
        .o_mem_stall(mem_stall), .o_dmem_req(dmem_req), .o_dmem_we(dmem_we),
        .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata), .o_dmem_be(dmem_be),
        .i_dmem_rdata(dmem_rdata), .i_dmem_ack(dmem_ack), .o_wb_valid(wb_valid),
        .o_wb_rd(wb_rd), .o_wb_regwrite(wb_regwrite), .o_wb_data(wb_data),
        .o_misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic        rw;
        logic        ld;
        logic        st;
        logic [2:0]  f3;
    } op_t;

    typedef struct {
        logic        misal;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] wb_data;
        logic [3:0]  be;
        logic        wb_rw;
    } exp_t;

    typedef struct {
        logic        valid;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        rw;
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic        ack;
        logic        e_valid;
        logic [31:0] e_data;
        logic [4:0]  e_rd;
        logic        e_rw;
        logic        e_mis;
        logic        chk_dat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, 32'(act), 32'(exp));
    endtask

    // Expected behaviour from access size in bytes and byte offset.
    function automatic exp_t ref_model(input op_t o, input logic [31:0] rdata);
        exp_t e;
        int unsigned sz;
        int unsigned off;
        longint m;
        longint v;
        case (o.f3)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            default:    sz = 4;
        endcase
        off     = o.res % 4;
        e.addr  = o.res - off;
        e.misal = (o.ld || o.st) && ((off % sz) != 0);
        e.be    = 4'hF;
        e.wdata = o.sdata;
        if (o.st) begin
            e.be = 4'(((32'd1 << sz) - 1) << off);
            if (sz == 1)      e.wdata = (o.sdata & 32'hFF) * 32'h0101_0101;
            else if (sz == 2) e.wdata = (o.sdata & 32'hFFFF) * 32'h0001_0001;
            e.wb_data = 32'h0;
            e.wb_rw   = 1'b0;
        end else if (o.ld) begin
            m = (64'sd1 << (8 * sz)) - 1;
            v = longint'(rdata >> (8 * off)) & m;
            if (o.f3 < 3'd4 && sz < 4 && v >= (64'sd1 << (8 * sz - 1)))
                v = v - (64'sd1 << (8 * sz));
            e.wb_data = 32'(v);
            e.wb_rw   = o.rw;
        end else begin
            e.wb_data = o.res;
            e.wb_rw   = o.rw;
        end
        if (e.misal) e.wb_rw = 1'b0;
        return e;
    endfunction

    // Presents one op at a negedge and follows it until its writeback.
    task automatic run_op(input op_t o, input int lat, input logic [31:0] rdata,
                          input exp_t e, input string tag);
        int stalls;
        ex_valid = 1'b1; ex_res = o.res; ex_store_data = o.sdata; ex_rd = o.rd;
        ex_regwrite = o.rw; ex_load = o.ld; ex_store = o.st; ex_funct3 = o.f3;
        @(negedge clk);
        if (!(o.ld || o.st)) begin
            ex_valid = 1'b0;
            chk1({tag, " alu wb_valid"}, wb_valid, 1'b1);
            chk({tag, " alu wb_data"}, wb_data, e.wb_data);
            chk({tag, " alu wb_rd"}, 32'(wb_rd), 32'(o.rd));
            chk1({tag, " alu wb_regwrite"}, wb_regwrite, e.wb_rw);
            chk1({tag, " alu stall"}, mem_stall, 1'b0);
        end else if (e.misal) begin
            ex_valid = 1'b0;
            chk1({tag, " mis misalign"}, misalign, 1'b1);
            chk1({tag, " mis wb_valid"}, wb_valid, 1'b1);
            chk1({tag, " mis wb_regwrite"}, wb_regwrite, 1'b0);
            chk1({tag, " mis dmem_req"}, dmem_req, 1'b0);
            chk1({tag, " mis stall"}, mem_stall, 1'b0);
        end else begin
            chk1({tag, " dmem_we"}, dmem_we, o.st);
            chk({tag, " dmem_be"}, 32'(dmem_be), 32'(e.be));
            if (o.st) chk({tag, " dmem_wdata"}, dmem_wdata, e.wdata);
            stalls = 0;
            for (int k = 0; k < lat; k++) begin
                if (mem_stall) stalls++;
                chk1({tag, " wait dmem_req"}, dmem_req, 1'b1);
                chk({tag, " wait dmem_addr"}, dmem_addr, e.addr);
                chk1({tag, " wait wb_valid"}, wb_valid, 1'b0);
                @(negedge clk);
            end
            if (mem_stall) stalls++;
            chk1({tag, " ack dmem_req"}, dmem_req, 1'b1);
            chk({tag, " ack dmem_addr"}, dmem_addr, e.addr);
            dmem_ack = 1'b1; dmem_rdata = rdata;
            @(negedge clk);
            dmem_ack = 1'b0; dmem_rdata = $urandom; ex_valid = 1'b0;
            chk({tag, " stall cycles"}, 32'(stalls), 32'(lat + 1));
            chk1({tag, " wb_valid"}, wb_valid, 1'b1);
            chk({tag, " wb_data"}, wb_data, e.wb_data);
            chk({tag, " wb_rd"}, 32'(wb_rd), 32'(o.rd));
            chk1({tag, " wb_regwrite"}, wb_regwrite, e.wb_rw);
            chk1({tag, " post stall"}, mem_stall, 1'b0);
            chk1({tag, " post dmem_req"}, dmem_req, 1'b0);
        end
    endtask

    initial begin
        vec_t vecs[9];
        op_t  o;
        exp_t e;
        logic [2:0] st_f3 [6];

        reset = 1'b1; ex_valid = 1'b0; ex_res = '0; ex_store_data = '0; ex_rd = '0;
        ex_regwrite = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = '0;
        dmem_rdata = '0; dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst wb_valid", wb_valid, 1'b0);
        chk1("rst wb_regwrite", wb_regwrite, 1'b0);
        chk("rst wb_rd", 32'(wb_rd), 32'h0);
        chk("rst wb_data", wb_data, 32'h0);
        chk1("rst dmem_req", dmem_req, 1'b0);
        chk1("rst dmem_we", dmem_we, 1'b0);
        chk("rst dmem_be", 32'(dmem_be), 32'h0);
        chk("rst dmem_addr", dmem_addr, 32'h0);
        chk("rst dmem_wdata", dmem_wdata, 32'h0);
        chk1("rst misalign", misalign, 1'b0);
        chk1("rst stall", mem_stall, 1'b0);
        reset = 1'b0;

        // valid res rd rw ld st f3 ack | e_valid e_data e_rd e_rw e_mis chk_dat
        vecs[0] = '{1'b1, 32'h0000_1234, 5'd5,  1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 32'h0000_1234, 5'd5,  1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 32'hDEAD_BEEF, 5'd31, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 32'hDEAD_BEEF, 5'd31, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 32'hCAFE_F00D, 5'd7,  1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'hDEAD_BEEF, 5'd31, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_0006, 5'd9,  1'b1, 1'b1, 1'b0, 3'b010, 1'b0, 1'b1, 32'h0,         5'd0,  1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0201, 5'd9,  1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 1'b1, 32'h0,         5'd0,  1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_0003, 5'd4,  1'b1, 1'b1, 1'b0, 3'b101, 1'b0, 1'b1, 32'h0,         5'd0,  1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 32'h0000_0102, 5'd4,  1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 1'b1, 32'h0,         5'd0,  1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 32'h0000_0055, 5'd3,  1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 32'h0000_0055, 5'd3,  1'b1, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 32'h0000_0000, 5'd0,  1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 32'h0000_0055, 5'd3,  1'b0, 1'b0, 1'b1};

        foreach (vecs[i]) begin
            ex_valid = vecs[i].valid; ex_res = vecs[i].res; ex_rd = vecs[i].rd;
            ex_regwrite = vecs[i].rw; ex_load = vecs[i].ld; ex_store = vecs[i].st;
            ex_funct3 = vecs[i].f3; dmem_ack = vecs[i].ack; dmem_rdata = 32'h1111_2222;
            @(negedge clk);
            ex_valid = 1'b0; dmem_ack = 1'b0;
            chk1($sformatf("vec%0d wb_valid", i), wb_valid, vecs[i].e_valid);
            chk1($sformatf("vec%0d misalign", i), misalign, vecs[i].e_mis);
            chk1($sformatf("vec%0d stall", i), mem_stall, 1'b0);
            chk1($sformatf("vec%0d dmem_req", i), dmem_req, 1'b0);
            if (vecs[i].e_valid) chk1($sformatf("vec%0d wb_regwrite", i), wb_regwrite, vecs[i].e_rw);
            if (vecs[i].chk_dat) begin
                chk($sformatf("vec%0d wb_data", i), wb_data, vecs[i].e_data);
                chk($sformatf("vec%0d wb_rd", i), 32'(wb_rd), 32'(vecs[i].e_rd));
            end
        end

        o = '{32'h0000_0103, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 3'b000};
        run_op(o, 3, 32'h80AA_BBCC, '{1'b0, 32'h0000_0100, 32'h0, 32'hFFFF_FF80, 4'hF, 1'b1}, "lb");
        o.f3 = 3'b100;
        run_op(o, 3, 32'h80AA_BBCC, '{1'b0, 32'h0000_0100, 32'h0, 32'h0000_0080, 4'hF, 1'b1}, "lbu");
        o = '{32'h0000_0202, 32'h1234_ABCD, 5'd11, 1'b1, 1'b0, 1'b1, 3'b001};
        run_op(o, 1, 32'h0, '{1'b0, 32'h0000_0200, 32'hABCD_ABCD, 32'h0, 4'b1100, 1'b0}, "sh");
        o = '{32'h0000_0042, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 3'b001};
        run_op(o, 0, 32'h9876_0000, '{1'b0, 32'h0000_0040, 32'h0, 32'hFFFF_9876, 4'hF, 1'b1}, "lh");

        // Reset two cycles into ACCESS, with the late ack arriving afterwards.
        ex_valid = 1'b1; ex_res = 32'h0000_0040; ex_rd = 5'd6; ex_regwrite = 1'b1;
        ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'b010;
        @(negedge clk);
        @(negedge clk);
        chk1("rstacc pre stall", mem_stall, 1'b1);
        reset = 1'b1; ex_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h5A5A_5A5A;
        chk1("rstacc dmem_req", dmem_req, 1'b0);
        chk1("rstacc stall", mem_stall, 1'b0);
        chk1("rstacc wb_valid", wb_valid, 1'b0);
        @(negedge clk);
        dmem_ack = 1'b0;
        chk1("rstacc late wb_valid", wb_valid, 1'b0);
        chk1("rstacc late stall", mem_stall, 1'b0);
        chk("rstacc late wb_data", wb_data, 32'h0);

        st_f3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
        for (int i = 0; i < 200; i++) begin
            logic [31:0] rd_word;
            int kind;
            kind = $urandom_range(0, 2);
            o.res = $urandom; o.sdata = $urandom; o.rd = 5'($urandom); o.rw = 1'($urandom);
            o.ld = (kind == 1); o.st = (kind == 2);
            o.f3 = o.st ? st_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
            rd_word = $urandom;
            e = ref_model(o, rd_word);
            run_op(o, $urandom_range(0, 4), rd_word, e, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
